// File: rtl/tx_port_arbiter_if.sv
// AXI-Stream bundle carrying LANES parallel lanes.
// The arbiter takes the multi-lane source side and drives the single-lane TX side.
interface tx_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1
);
  logic [LANES*DATA_WIDTH-1:0]   tdata;
  logic [LANES*DATA_WIDTH/8-1:0] tstrb;
  logic [LANES-1:0]              tvalid;
  logic [LANES-1:0]              tlast;
  logic [LANES-1:0]              tready;

  modport master (
    output tdata, tstrb, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/tx_port_arbiter.sv
// Packet-granular round-robin arbiter feeding the 1G TX datapath.
// Grants one source per packet, forwards it until tlast, then idles GAP_CYCLES.
module tx_port_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_ID_WIDTH = 2,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  tx_port_arbiter_if.slave          s,
  tx_port_arbiter_if.master         m,
  input  logic [NUM_QUEUES-1:0]     queue_en,
  output logic [QUEUE_ID_WIDTH-1:0] grant_id,
  output logic                      busy,
  output logic                      pkt_done
);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [QUEUE_ID_WIDTH-1:0] LAST_Q =
    QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
  localparam logic [7:0] GAP_END =
    (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [QUEUE_ID_WIDTH-1:0] rr_ptr;
  logic [QUEUE_ID_WIDTH-1:0] rr_nxt;
  logic [QUEUE_ID_WIDTH-1:0] grant_nxt;
  logic [QUEUE_ID_WIDTH-1:0] pick;
  logic [7:0]                gap_cnt;
  logic [7:0]                gap_nxt;
  logic [NUM_QUEUES-1:0]     cand;
  logic                      found;
  logic                      xfer;

  assign cand = s.tvalid & queue_en;

  // Scan rr_ptr+1 .. rr_ptr+NUM_QUEUES, wrapping at NUM_QUEUES
  always_comb begin
    int                        idx;
    logic [QUEUE_ID_WIDTH-1:0] qi;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    qi    = '0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_QUEUES;
      qi  = QUEUE_ID_WIDTH'(idx);
      if (!found && cand[qi]) begin
        found = 1'b1;
        pick  = qi;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    grant_nxt = grant_id;
    gap_nxt   = gap_cnt;
    m.tdata   = '0;
    m.tstrb   = '0;
    m.tvalid  = 1'b0;
    m.tlast   = 1'b0;
    s.tready  = '0;
    busy      = 1'b0;
    pkt_done  = 1'b0;
    xfer      = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          state_nxt = SEND;
        end
      end
      SEND: begin
        busy = 1'b1;
        for (int i = 0; i < NUM_QUEUES; i++) begin
          if (grant_id == QUEUE_ID_WIDTH'(i)) begin
            m.tdata     = s.tdata[i*DATA_WIDTH +: DATA_WIDTH];
            m.tstrb     = s.tstrb[i*SW +: SW];
            m.tvalid    = s.tvalid[i];
            m.tlast     = s.tlast[i];
            s.tready[i] = m.tready;
          end
        end
        xfer = m.tvalid & m.tready;
        // Served queue drops to lowest priority for the next scan
        if (xfer && m.tlast) begin
          pkt_done  = 1'b1;
          rr_nxt    = grant_id;
          gap_nxt   = '0;
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_END) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      rr_ptr   <= LAST_Q;
      grant_id <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      grant_id <= grant_nxt;
      gap_cnt  <= gap_nxt;
    end
  end
endmodule

// File: tb/tb_tx_port_arbiter.sv
// Directed and randomized checks of tx_port_arbiter against a
// packet-level reference model (source queues plus grant timing rules).
module tb_tx_port_arbiter;
  localparam int NQ  = 4;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NQ-1:0] queue_en;
  logic [1:0]    grant_id;
  logic          busy;
  logic          pkt_done;

  tx_port_arbiter_if #(.DATA_WIDTH(8), .LANES(NQ)) sif ();
  tx_port_arbiter_if #(.DATA_WIDTH(8), .LANES(1))  mif ();

  tx_port_arbiter #(
    .DATA_WIDTH(8), .NUM_QUEUES(NQ),
    .QUEUE_ID_WIDTH(2), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s(sif), .m(mif),
    .queue_en(queue_en), .grant_id(grant_id),
    .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Source side: per-queue beat lists
  byte unsigned sdat  [NQ][$];
  bit           slast [NQ][$];
  bit           sstrb [NQ][$];
  bit           pres  [NQ];
  int           bubble  = 0;
  int           rdy_pct = 100;
  bit           rdy_pat [$];

  // Reference model state
  int own       = -1;
  int last_g    = NQ - 1;
  int mgrant    = 0;
  int idle_from = 0;
  int cyc       = 0;

  // Observations
  int busy_cnt = 0;
  int nx       = 0;
  int xfer_cyc  [$];
  bit xfer_last [$];
  int dut_order [$];

  logic [NQ-1:0] s_rdy_smp;
  logic          m_rdy_smp;
  logic          rst_smp;
  logic [NQ-1:0] en_smp;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  function automatic bit any_src();
    bit r = 0;
    for (int q = 0; q < NQ; q++) if (sdat[q].size() > 0) r = 1;
    return r;
  endfunction

  task automatic add_pkt(input int q, input int len);
    for (int b = 0; b < len; b++) begin
      sdat[q].push_back(8'($urandom));
      slast[q].push_back(b == len - 1);
      sstrb[q].push_back(1'($urandom));
    end
  endtask

  task automatic drive();
    for (int q = 0; q < NQ; q++) begin
      if (!pres[q] && sdat[q].size() > 0 &&
          $urandom_range(99) >= bubble)
        pres[q] = 1;
      sif.tvalid[q]       = pres[q];
      sif.tdata[q*8 +: 8] = pres[q] ? sdat[q][0] : 8'($urandom);
      sif.tstrb[q]        = pres[q] ? sstrb[q][0] : 1'b0;
      sif.tlast[q]        = pres[q] ? slast[q][0] : 1'b0;
    end
    if (rdy_pat.size() > 0) mif.tready = rdy_pat.pop_front();
    else mif.tready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic check();
    logic          ev;
    logic          el;
    logic          epd;
    logic [NQ-1:0] erdy;
    ev = 0; el = 0; epd = 0; erdy = '0;
    if (own >= 0) begin
      ev = pres[own];
      if (ev) el = slast[own][0];
      if (mif.tready) erdy[own] = 1'b1;
      epd = ev & mif.tready & el;
    end
    chk("m_tvalid", mif.tvalid, ev);
    chk("s_tready", sif.tready, erdy);
    chk("busy", busy, own >= 0);
    chk("grant_id", grant_id, mgrant);
    chk("pkt_done", pkt_done, epd);
    if (ev) begin
      chk("m_tdata", mif.tdata, sdat[own][0]);
      chk("m_tstrb", mif.tstrb, sstrb[own][0]);
      chk("m_tlast", mif.tlast, el);
    end
    if (busy === 1'b1) busy_cnt++;
    if (mif.tvalid === 1'b1 && mif.tready === 1'b1) begin
      nx++;
      xfer_cyc.push_back(cyc);
      xfer_last.push_back(mif.tlast);
    end
    if (pkt_done === 1'b1) dut_order.push_back(int'(grant_id));
    s_rdy_smp = sif.tready;
    m_rdy_smp = mif.tready;
    rst_smp   = resetn;
    en_smp    = queue_en;
  endtask

  task automatic update();
    int idx;
    if (!rst_smp) begin
      own = -1; last_g = NQ - 1; mgrant = 0; idle_from = cyc + 1;
      for (int q = 0; q < NQ; q++) begin
        sdat[q].delete(); slast[q].delete(); sstrb[q].delete();
        pres[q] = 0;
      end
    end else begin
      if (own >= 0) begin
        if (pres[own] && m_rdy_smp && slast[own][0]) begin
          last_g = own; own = -1; idle_from = cyc + GAP + 1;
        end
      end else if (cyc >= idle_from) begin
        for (int k = 1; k <= NQ; k++) begin
          idx = (last_g + k) % NQ;
          if (own < 0 && pres[idx] && en_smp[idx]) own = idx;
        end
        if (own >= 0) mgrant = own;
      end
      for (int q = 0; q < NQ; q++) begin
        if (pres[q] && s_rdy_smp[q]) begin
          void'(sdat[q].pop_front());
          void'(slast[q].pop_front());
          void'(sstrb[q].pop_front());
          pres[q] = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((own >= 0 || any_src()) && n < max) begin
      step(); n++;
    end
    chk("drain_timeout", (own >= 0 || any_src()), 0);
  endtask

  task automatic run_grants(input int cnt, input int max);
    int n = 0;
    while (dut_order.size() < cnt && n < max) begin
      step(); n++;
    end
    chk("grant_timeout", dut_order.size() >= cnt, 1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    dut_order.delete();
    nx = 0;
  endtask

  initial begin
    int c0;
    int g;
    int exp2 [6] = '{0, 1, 2, 3, 0, 1};
    int exp3 [4] = '{0, 1, 3, 0};
    resetn     = 1'b0;
    queue_en   = '1;
    sif.tdata  = '0;
    sif.tstrb  = '0;
    sif.tvalid = '0;
    sif.tlast  = '0;
    mif.tready = 1'b1;
    for (int q = 0; q < NQ; q++) pres[q] = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state, then queue 0 sends two 5-beat packets
    step();
    busy_cnt = 0; nx = 0; xfer_cyc.delete(); xfer_last.delete();
    dut_order.delete();
    add_pkt(0, 5); add_pkt(0, 5);
    c0 = cyc;
    drain(100);
    chk("p1_busy_cycles", busy_cnt, 10);
    chk("p1_beats", xfer_cyc.size(), 10);
    if (xfer_cyc.size() == 10) begin
      chk("p1_first_beat", xfer_cyc[0], c0 + 1);
      chk("p1_tlast_beat5", xfer_last[4], 1);
      chk("p1_idle_between", xfer_cyc[5] - xfer_cyc[4] - 1, GAP + 1);
    end
    chk("p1_grants", dut_order.size(), 2);

    // All queues requesting: strict rotation
    do_reset();
    add_pkt(0, 3); add_pkt(1, 3); add_pkt(2, 3); add_pkt(3, 3);
    add_pkt(0, 3); add_pkt(1, 3);
    drain(200);
    chk("p2_count", dut_order.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < dut_order.size())
        chk($sformatf("p2_order%0d", i), dut_order[i], exp2[i]);

    // Queue 2 disabled
    do_reset();
    queue_en = 4'b1011;
    add_pkt(0, 3); add_pkt(1, 3); add_pkt(2, 3); add_pkt(3, 3);
    add_pkt(0, 3);
    run_grants(4, 200);
    for (int i = 0; i < 4; i++)
      if (i < dut_order.size())
        chk($sformatf("p3_order%0d", i), dut_order[i], exp3[i]);
    queue_en = '1;
    drain(200);
    if (dut_order.size() == 5) chk("p3_q2_late", dut_order[4], 2);
    else chk("p3_count", dut_order.size(), 5);

    // Downstream backpressure during a 4-beat packet
    do_reset();
    add_pkt(1, 4);
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drain(50);
    rdy_pat.delete();
    chk("p4_beats", nx, 4);
    chk("p4_grants", dut_order.size(), 1);
    if (dut_order.size() == 1) chk("p4_queue", dut_order[0], 1);

    // Enable drop mid-packet
    do_reset();
    add_pkt(0, 6); add_pkt(0, 3); add_pkt(1, 2);
    g = 0;
    while (nx < 1 && g < 50) begin step(); g++; end
    queue_en = 4'b1110;
    run_grants(2, 100);
    if (dut_order.size() == 2) begin
      chk("p5_first", dut_order[0], 0);
      chk("p5_second", dut_order[1], 1);
    end
    repeat (12) step();
    chk("p5_no_regrant", dut_order.size(), 2);
    chk("p5_beats", nx, 8);
    queue_en = '1;
    drain(100);

    // Reset in the middle of a packet
    do_reset();
    add_pkt(2, 2);
    drain(50);
    add_pkt(2, 6);
    nx = 0; g = 0;
    while (nx < 2 && g < 50) begin step(); g++; end
    do_reset();
    step();
    chk("p6_busy_after", busy, 0);
    chk("p6_grant_after", grant_id, 0);
    add_pkt(2, 3); add_pkt(3, 3);
    drain(100);
    chk("p6_count", dut_order.size(), 2);
    if (dut_order.size() == 2) begin
      chk("p6_first", dut_order[0], 2);
      chk("p6_second", dut_order[1], 3);
    end

    // Randomized traffic with bubbles, backpressure and enable churn
    do_reset();
    bubble = 30; rdy_pct = 70;
    for (int q = 0; q < NQ; q++)
      for (int p = 0; p < 6; p++) add_pkt(q, $urandom_range(1, 8));
    for (int i = 0; i < 3000 && (own >= 0 || any_src()); i++) begin
      if (i % 25 == 0) queue_en = 4'($urandom_range(1, 15));
      step();
    end
    queue_en = '1;
    drain(2000);
    chk("p7_packets", dut_order.size(), 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tx_port_arbiter.md
Name: tx_port_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one 1G TX datapath among NUM_QUEUES AXI-Stream packet sources.
- Sits upstream of the TX AXI-to-MAC converter in the clk domain.
- Grants one source at a time and forwards its packet unmodified until tlast.
- Enforces a programmable idle gap between packets and exposes per-queue enables and grant status.

Parameters:
- DATA_WIDTH, 8, AXI-Stream data width. Only 8 is supported in 1G mode.
- NUM_QUEUES, 4, number of input sources (2..8).
- QUEUE_ID_WIDTH, 2, width of queue index. Requires NUM_QUEUES <= 2**QUEUE_ID_WIDTH.
- GAP_CYCLES, 2, idle cycles inserted after each packet (0..255). 0 means no gap state.

Ports:
- clk  in  1  single clock for the whole block.
- resetn  in  1  synchronous reset, active-low.
- s_tdata  in  NUM_QUEUES*DATA_WIDTH  input data, queue i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tstrb  in  NUM_QUEUES*DATA_WIDTH/8  input byte strobes, packed per queue.
- s_tvalid  in  NUM_QUEUES  per-queue valid.
- s_tlast  in  NUM_QUEUES  per-queue end of packet.
- s_tready  out  NUM_QUEUES  per-queue ready.
- m_tdata  out  DATA_WIDTH  output data to the TX converter.
- m_tstrb  out  DATA_WIDTH/8  output strobes.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output end of packet.
- m_tready  in  1  downstream ready (converter FIFO not almost full).
- queue_en  in  NUM_QUEUES  per-queue arbitration enable.
- grant_id  out  QUEUE_ID_WIDTH  index of the currently or last granted queue.
- busy  out  1  high while in SEND.
- pkt_done  out  1  one-cycle pulse on the final beat of each forwarded packet.

Behaviour:
- Reset (resetn=0 at posedge clk), applied regardless of state, including mid-packet:
  - state=IDLE, rr_ptr=NUM_QUEUES-1 (queue 0 has first priority), grant_id=0, gap counter=0.
  - busy=0, pkt_done=0, m_tvalid=0, s_tready all 0.
  - A packet cut by reset is not resumed. The upstream source must also be reset.
- State machine: IDLE, SEND, GAP.
- IDLE:
  - m_tvalid=0 and all s_tready=0.
  - Candidate set is s_tvalid & queue_en.
  - If the set is non-empty, select the first candidate scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_QUEUES.
  - Register the selection into grant_id and go to SEND.
  - Arbitration latency is 1 cycle: the first beat can transfer no earlier than the cycle after the request is seen in IDLE.
- SEND:
  - Combinational forward: m_tdata/m_tstrb/m_tvalid/m_tlast take the granted queue's slice.
  - s_tready[grant_id]=m_tready. All other s_tready=0.
  - busy=1.
  - A beat transfers when m_tvalid & m_tready.
  - A transfer with m_tlast=1: pkt_done=1 that cycle, rr_ptr<=grant_id, next state is GAP if GAP_CYCLES>0, else IDLE.
  - Deasserting queue_en[grant_id] mid-packet does not abort the packet. Enable is sampled only in IDLE.
  - s_tvalid dropping mid-packet stalls the output (m_tvalid=0) with the grant held.
- GAP:
  - m_tvalid=0, all s_tready=0.
  - Counter loads 0 on entry, increments each cycle, and exits to IDLE when it reaches GAP_CYCLES-1, giving exactly GAP_CYCLES idle cycles.
- Minimum spacing between the last beat of one packet and the first beat of the next is GAP_CYCLES+1 cycles (gap plus IDLE arbitration).
- Fairness:
  - The just-served queue gets lowest priority at the next arbitration.
  - With all queues continuously requesting, grants cycle 0,1,2,3,0,...
  - With only one requester, it is granted back-to-back, subject to the gap.
- Single-beat packet (tvalid and tlast on the first beat): legal. SEND lasts one transfer cycle.
- Bits of s_tvalid for indices >= NUM_QUEUES do not exist. Queue index arithmetic wraps modulo NUM_QUEUES, not 2**QUEUE_ID_WIDTH.

Test Plan:
- Reset, then queue 0 sends a 5-beat packet with m_tready=1 -> grant_id=0, busy high 5 cycles, m_tdata matches input, pkt_done pulses on beat 5, next first beat no earlier than 3 cycles later (GAP_CYCLES=2).
- All 4 queues hold 3-beat packets continuously -> grant order 0,1,2,3,0,1. No interleaving of beats between packets.
- queue_en=4'b1011 with all queues requesting -> queue 2 is never granted; order 0,1,3,0.
- m_tready toggles 1,0,0,1 during a 4-beat packet -> s_tready of the granted queue mirrors m_tready; only the granted queue sees ready; packet completes after 4 accepted beats; data is unchanged.
- queue_en[grant_id] drops on beat 2 of a 6-beat packet -> all 6 beats are forwarded, then the queue is excluded from the next arbitration.
- resetn pulses low on beat 3 of a packet -> next cycle m_tvalid=0, busy=0, grant_id=0, all s_tready=0; a subsequent request from queue 2 is granted first (rr_ptr reset to 3).
